// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, request op codes and the latched request.
package dmem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Encoded as {memwrite, memread} so the request inputs map straight onto the op.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RDWR = 2'b11
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with registered read data; contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline LATENCY+1 cycles per access, then presents load data.
// Optional access counters (rd_count/wr_count/err_count) are added when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        rdata_valid,
    output logic        stall,
    output logic        misalign
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] err_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic [31:0]      rdata_hold_q, rdata_hold_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             misalign_q, misalign_d;
    logic             load_ok_q, load_ok_d;

    logic             access;
    logic             aligned;
    logic             err;
    logic             ram_we;
    logic             ram_re;
    logic [31:0]      ram_rdata;
    logic             unused_addr_bits;

    assign aligned = (req_q.addr[1:0] == 2'b00);
    assign err     = !aligned || (req_q.op == OP_RDWR);
    assign access  = (state_q == ST_WAIT) && (cnt_q == '0);

    // RAM has no reset, so a reset landing on the access edge must suppress the write.
    assign ram_we = access && rst_n && req_q.op[1] && aligned;
    assign ram_re = access && rst_n && (req_q.op == OP_RD) && aligned;

    assign unused_addr_bits = ^req_q.addr[31:IDX_W+2];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (req_q.addr[IDX_W+1:2]),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    // In DONE a good load shows the fresh RAM word, a misaligned load shows zero.
    assign read_data   = load_ok_q ? ram_rdata : (rdata_valid_q ? 32'h0 : rdata_hold_q);
    assign rdata_valid = rdata_valid_q;
    assign misalign    = misalign_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        rdata_hold_d  = rdata_hold_q;
        rdata_valid_d = 1'b0;
        misalign_d    = 1'b0;
        load_ok_d     = 1'b0;
        stall         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = memread | memwrite;
                if (memread | memwrite) begin
                    req_d.op    = op_e'({memwrite, memread});
                    req_d.addr  = addr;
                    req_d.wdata = write_data;
                    cnt_d       = CNT_INIT;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_valid_d = (req_q.op == OP_RD);
                    misalign_d    = err;
                    load_ok_d     = (req_q.op == OP_RD) && aligned;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rdata_valid_q) begin
                    rdata_hold_d = read_data;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            req_q         <= '0;
            rdata_hold_q  <= '0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            load_ok_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            rdata_hold_q  <= rdata_hold_d;
            rdata_valid_q <= rdata_valid_d;
            misalign_q    <= misalign_d;
            load_ok_q     <= load_ok_d;
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic [31:0] err_count_q, err_count_d;

    // Error accesses land only in err_count, whatever their op.
    always_comb begin
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        if (access) begin
            if (err) begin
                err_count_d = err_count_q + 32'd1;
            end else if (req_q.op == OP_RD) begin
                rd_count_d = rd_count_q + 32'd1;
            end else begin
                wr_count_d = wr_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases followed by random loads/stores against a word-array model.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        rdata_valid;
    logic        stall;
    logic        misalign;
`ifdef DMEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [31:0] err_count;
`endif

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .memread     (memread),
        .memwrite    (memwrite),
        .addr        (addr),
        .write_data  (write_data),
        .read_data   (read_data),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .misalign    (misalign)
`ifdef DMEM_STATS_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .err_count   (err_count)
`endif
    );

    typedef struct {
        logic        rv;
        logic        mis;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_last = 32'h0;
    int unsigned m_rd = 0, m_wr = 0, m_err = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour: one complete access against a plain word array.
    task automatic model_issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int unsigned idx;
        logic        odd;
        idx = (a >> 2) % DEPTH;
        odd = (a % 4) != 0;
        if (wr && !odd) model_mem[idx] = wd;
        if (rd && !wr) model_last = odd ? 32'h0 : model_mem[idx];
        e.rv   = rd && !wr;
        e.mis  = odd || (rd && wr);
        e.data = model_last;
        if (e.mis) m_err++;
        else if (rd) m_rd++;
        else m_wr++;
        exp_q.push_back(e);
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        memread    = rd;
        memwrite   = wr;
        addr       = a;
        write_data = wd;
        model_issue(rd, wr, a, wd);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
        end
        memread  = 1'b0;
        memwrite = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL txn_timeout: stall still 1 after 40 cycles, expected release after %0d", LAT + 1);
        end
    endtask

    // Monitor: a falling stall marks the DONE cycle; compare it against the oldest expectation.
    int run_len = 0;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len    = 0;
            prev_stall = 1'b0;
        end else if (stall) begin
            run_len++;
            prev_stall = 1'b1;
        end else begin
            if (prev_stall) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got a DONE cycle, expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("stall_cycles", 32'(run_len), 32'(LAT + 1));
                    check("rdata_valid", {31'h0, rdata_valid}, {31'h0, mon_e.rv});
                    check("misalign", {31'h0, misalign}, {31'h0, mon_e.mis});
                    check("read_data", read_data, mon_e.data);
                end
            end
            run_len    = 0;
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int unsigned r;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_read_data", read_data, 32'h0);
        check("reset_rdata_valid", {31'h0, rdata_valid}, 32'h0);
        check("reset_misalign", {31'h0, misalign}, 32'h0);
        check("reset_stall", {31'h0, stall}, 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            if (r == 32'hDEADBEEF) r = 32'h1;
            do_txn(1'b0, 1'b1, 32'(i * 4), r);
        end

        // Reset in the middle of a store's wait must drop the write.
        @(posedge clk);
        #1;
        memwrite   = 1'b1;
        addr       = 32'h10;
        write_data = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        memwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_last = 32'h0;
        m_rd = 0; m_wr = 0; m_err = 0;
        check("midwait_rst_read_data", read_data, 32'h0);
        check("midwait_rst_rdata_valid", {31'h0, rdata_valid}, 32'h0);
        check("midwait_rst_misalign", {31'h0, misalign}, 32'h0);
        check("midwait_rst_stall", {31'h0, stall}, 32'h0);
        do_txn(1'b1, 1'b0, 32'h10, 32'h0);

        do_txn(1'b0, 1'b1, 32'h20, 32'h12345678);
        do_txn(1'b1, 1'b0, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        check("hold_read_data", read_data, 32'h12345678);
        check("hold_rdata_valid", {31'h0, rdata_valid}, 32'h0);

        do_txn(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
        do_txn(1'b1, 1'b0, 32'h0, 32'h0);

        do_txn(1'b1, 1'b0, 32'h22, 32'h0);
        do_txn(1'b0, 1'b1, 32'h23, 32'hFFFFFFFF);
        do_txn(1'b1, 1'b0, 32'h20, 32'h0);

        do_txn(1'b1, 1'b1, 32'h30, 32'h55);
        do_txn(1'b1, 1'b0, 32'h30, 32'h0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 7);
            a = (32'($urandom_range(0, 15)) << 10) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if (r < 4) do_txn(1'b1, 1'b0, a, 32'h0);
            else if (r < 7) do_txn(1'b0, 1'b1, a, $urandom);
            else do_txn(1'b1, 1'b1, a, $urandom);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

`ifdef DMEM_STATS_EN
        @(negedge clk);
        check("rd_count", rd_count, m_rd);
        check("wr_count", wr_count, m_wr);
        check("err_count", err_count, m_err);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
